// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instr_encoder_pkg
// Shared types and constants for the RV32I instruction encoder.
//   fmt_e   : instruction format selector carried on in_fmt
//   state_e : RUN/HALT state of the encoder control FSM
//   WIDTH   : encoded instruction word width
//   OP_*    : base opcodes for the supported formats
// ---------------------------------------------------------------------------
package instr_encoder_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Combinational field packer: RV32I fields + full immediate -> instruction
// word, plus an error flag for bundles that cannot be encoded.
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined     : immediates are range/alignment checked per format
//   not defined : immediate bits are truncated silently; only an undefined
//                 format raises err
// Ports:
//   fmt    in  3      format selector (fmt_e encoding)
//   opcode in  7      opcode field
//   rd     in  5      destination register
//   funct3 in  3      funct3 field
//   rs1    in  5      source register 1
//   rs2    in  5      source register 2
//   funct7 in  7      funct7 field
//   imm    in  32     full signed byte-offset immediate
//   word   out WIDTH  packed instruction (0 for an undefined format)
//   err    out 1      bundle failed encoding
// ---------------------------------------------------------------------------
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [2:0]       fmt,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [2:0]       funct3,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [6:0]       funct7,
   input  logic [31:0]      imm,
   output logic [WIDTH-1:0] word,
   output logic             err
);

`ifdef ENC_RANGE_CHECK_EN
   logic signed [31:0] imm_s;
   assign imm_s = $signed(imm);
`endif

   always_comb begin
      word = '0;
      err  = 1'b0;
      case (fmt)
         FMT_R: begin
            word = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         FMT_I: begin
            word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
            err  = (imm_s < -2048) || (imm_s > 2047);
`endif
         end
         FMT_S: begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef ENC_RANGE_CHECK_EN
            err  = (imm_s < -2048) || (imm_s > 2047);
`endif
         end
         FMT_B: begin
            // imm[0] has no slot: branch targets are 2-byte aligned.
            word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef ENC_RANGE_CHECK_EN
            err  = (imm_s < -4096) || (imm_s > 4094) || imm[0];
`endif
         end
         FMT_U: begin
            word = {imm[31:12], rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
            err  = (imm[11:0] != 12'd0);
`endif
         end
         FMT_J: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
            err  = (imm_s < -1048576) || (imm_s > 1048574) || imm[0];
`endif
         end
         default: begin
            word = '0;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Packs RV32I field bundles into instruction words for the program loader /
// instruction-memory write port, tagging each with a sequential word address.
// One-deep registered output stage with valid/ready on both sides and a
// RUN/HALT FSM that stops intake after an encode error.
// Optional feature macro: ENC_RANGE_CHECK_EN (immediate range checking,
// see instr_pack).
//
// Handshake: a transfer happens on a posedge where valid && ready are both
// high. in_ready = RUN && (!out_valid || out_ready); an accepted bundle loads
// the output registers, so out_* hold steady while out_valid && !out_ready.
//
// Parameters:
//   BASE_ADDR   word address loaded on reset and flush
//   STOP_ON_ERR 1: an accepted erroneous bundle enters HALT; 0: flag only
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 sync clear of output stage, address and FSM
//   in_valid / in_ready   input handshake
//   in_fmt .. in_imm      field bundle
//   out_valid / out_ready output handshake
//   out_instr             encoded word
//   out_addr              word address of out_instr
//   out_err               out_instr came from an erroneous bundle
//   halted                FSM is in HALT (state observation)
// ---------------------------------------------------------------------------
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter bit          STOP_ON_ERR = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic [31:0]      out_addr,
   output logic             out_err,
   output logic             halted
);

   state_e           state_q;
   state_e           state_d;
   logic [31:0]      cnt_q;
   logic [WIDTH-1:0] pack_word;
   logic             pack_err;
   logic             accept;

   instr_pack u_pack (
      .fmt    (in_fmt),
      .opcode (in_opcode),
      .rd     (in_rd),
      .funct3 (in_funct3),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .word   (pack_word),
      .err    (pack_err)
   );

   assign in_ready = (state_q == ST_RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign halted   = (state_q == ST_HALT);

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_RUN;
      end else if (accept && pack_err && STOP_ON_ERR) begin
         state_d = ST_HALT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Output stage and address counter. flush wins over any handshake in the
   // same cycle, so a word accepted or pending at that edge is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= BASE_ADDR;
         out_err   <= 1'b0;
         cnt_q     <= BASE_ADDR;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= BASE_ADDR;
         out_err   <= 1'b0;
         cnt_q     <= BASE_ADDR;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_instr <= pack_word;
         out_addr  <= cnt_q;
         out_err   <= pack_err;
         cnt_q     <= cnt_q + 32'd1;  // wraps to 0 silently
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder. BASE_ADDR sits two below the 32-bit top
// so the address counter wraps inside the streaming section.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_FFFE;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_fmt = 3'd0;
   logic [6:0]       in_opcode = 7'd0;
   logic [4:0]       in_rd = 5'd0;
   logic [2:0]       in_funct3 = 3'd0;
   logic [4:0]       in_rs1 = 5'd0;
   logic [4:0]       in_rs2 = 5'd0;
   logic [6:0]       in_funct7 = 7'd0;
   logic [31:0]      in_imm = 32'd0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_instr;
   logic [31:0]      out_addr;
   logic             out_err;
   logic             halted;

   instr_encoder #(.BASE_ADDR(BASE), .STOP_ON_ERR(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_funct3 (in_funct3),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .halted    (halted)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [6:0] f7, input logic [31:0] imm);
      in_fmt    = fmt;
      in_opcode = op;
      in_rd     = rd;
      in_funct3 = f3;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct7 = f7;
      in_imm    = imm;
      in_valid  = 1'b1;
   endtask

   task automatic drive_addi();
      drive(FMT_I, OP_I, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
   endtask

   // one bundle in, one word out on the next edge
   task automatic send_check(input string tag, input logic [31:0] exp_instr,
                             input logic [31:0] exp_addr, input logic exp_err);
      @(negedge clk);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_instr"}, out_instr, exp_instr);
      chk({tag, "_addr"}, out_addr, exp_addr);
      chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd_word [3];
      rd_word[0] = 32'h002081B3;
      rd_word[1] = 32'h002082B3;
      rd_word[2] = 32'h002083B3;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_addr", out_addr, BASE);
      chk("rst_err", {31'd0, out_err}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. addi x1, x0, 5
      drive_addi();
      send_check("addi", 32'h00500093, BASE, 1'b0);

      // 2. back-to-back adds, addresses wrap FFFFFFFF -> 0
      for (int i = 0; i < 3; i++) begin
         chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
         drive(FMT_R, OP_R, 5'd3 + 5'(2 * i), 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
         exp_q.push_back(rd_word[i]);
         exp_addr_q.push_back(32'hFFFF_FFFF + 32'(i));
         @(negedge clk);
         chk("b2b_valid", {31'd0, out_valid}, 32'd1);
         chk("b2b_instr", out_instr, exp_q.pop_front());
         chk("b2b_addr", out_addr, exp_addr_q.pop_front());
      end

      // 3. sw x2, 8(x1) then beq x1, x2, -4
      drive(FMT_S, OP_S, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
      send_check("sw", 32'h0020A423, 32'd2, 1'b0);
      drive(FMT_B, OP_B, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, -32'sd4);
      send_check("beq", 32'hFE208EE3, 32'd3, 1'b0);

      // 4. jal x1, 2048 then stall three cycles with a bundle waiting
      drive(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
      send_check("jal", 32'h001000EF, 32'd4, 1'b0);
      out_ready = 1'b0;
      drive_addi();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_instr", out_instr, 32'h001000EF);
         chk("stall_addr", out_addr, 32'd4);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      send_check("post_stall", 32'h00500093, 32'd5, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // 5a. I immediate at the top of its legal range
      drive(FMT_I, OP_I, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2047);
      send_check("imm2047", 32'h7FF00093, 32'd6, 1'b0);

      // 5b. undefined format: word 0, error, HALT; later bundle refused
      drive(3'd7, OP_I, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
      send_check("badfmt", 32'd0, 32'd7, 1'b1);
      chk("badfmt_halted", {31'd0, halted}, 32'd1);
      chk("badfmt_in_ready", {31'd0, in_ready}, 32'd0);
      drive_addi();
      @(negedge clk);
      chk("halt_drained", {31'd0, out_valid}, 32'd0);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_halted", {31'd0, halted}, 32'd0);
      chk("flush_addr", out_addr, BASE);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

      // 5c. misaligned branch offset: flagged only with range checking
      drive(FMT_B, OP_B, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3);
`ifdef ENC_RANGE_CHECK_EN
      send_check("beq_odd", 32'h00208163, BASE, 1'b1);
      chk("beq_odd_halted", {31'd0, halted}, 32'd1);
      chk("beq_odd_in_ready", {31'd0, in_ready}, 32'd0);
`else
      send_check("beq_odd", 32'h00208163, BASE, 1'b0);
      chk("beq_odd_halted", {31'd0, halted}, 32'd0);
`endif
      in_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush2_halted", {31'd0, halted}, 32'd0);
      chk("flush2_valid", {31'd0, out_valid}, 32'd0);

      // 6. flush with a word stalled at the output
      drive_addi();
      send_check("pre_flush", 32'h00500093, BASE, 1'b0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("stalled_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      #1;
      chk("flush_sync_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_drop_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_drop_addr", out_addr, BASE);
      out_ready = 1'b1;
      drive_addi();
      send_check("after_flush", 32'h00500093, BASE, 1'b0);
      drive_addi();
      send_check("after_flush2", 32'h00500093, BASE + 32'd1, 1'b0);

      // reset with a word stalled at the output: dropped immediately
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_instr", out_instr, 32'd0);
      chk("arst_addr", out_addr, BASE);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      drive_addi();
      send_check("after_rst", 32'h00500093, BASE, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
